sigmoid_eval_ctrl: RTL and testbench
====================================

// Module: sigmoid_eval_ctrl
// PURPOSE
//   Sequences one evaluation of the stochastic sigmoid datapath. Accepts a binary operand over a
//   valid/ready handshake and converts it to a unipolar bitstream with an internal LFSR comparator.
//   It drives that stream into sigmoid.x, discards the settling window, then counts ones on
//   sigmoid.y over a fixed stream length. The count is returned as a binary result on a second
//   valid/ready handshake. There is one instance per sigmoid neuron, between the layer sequencer and
//   the neuron.
// PARAMETERS
//   WIDTH      8     operand/result width; LFSR width; STREAM_LEN must equal 2**WIDTH
//   STREAM_LEN 256   accumulate-window length in cycles
//   WARMUP     16    settle cycles (stream driven, y ignored) before accumulation; >=1
//   SEED       8'h5A LFSR load value at each accepted operand; must be non-zero
// PORTS
//   clk        in   1      clock; all state on rising edge
//   n_rst      in   1      asynchronous active-low reset
//   in_valid   in   1      operand offered
//   in_ready   out  1      operand accepted when in_valid & in_ready
//   in_value   in   WIDTH  operand, unsigned, P(x=1) = in_value/2**WIDTH
//   abort      in   1      synchronous cancel of the current evaluation
//   x_out      out  1      bitstream to sigmoid.x
//   y_in       in   1      bitstream from sigmoid.y
//   out_valid  out  1      result available
//   out_ready  in   1      result consumed when out_valid & out_ready
//   result     out  WIDTH  ones count over the window, saturated to 2**WIDTH-1
//   busy       out  1      high in WARMUP or ACCUM
// BEHAVIOUR
// - Reset (n_rst low, async): state=IDLE; in_ready=1; x_out=0; out_valid=0; result=0; busy=0;
//   LFSR=SEED; counters=0.
// - FSM IDLE -> WARMUP -> ACCUM -> DONE -> IDLE.
// - IDLE: in_ready=1, x_out=0. On an in handshake: latch in_value, load LFSR=SEED, zero both
//   counters, go to WARMUP next cycle. in_ready=0 in every other state.
// - LFSR: Fibonacci, polynomial x^8+x^6+x^5+x^4+1 (for WIDTH=8), period 255. Shifts every cycle in
//   WARMUP/ACCUM and holds otherwise.
// - x_out is registered: x_out <= (value > lfsr) in WARMUP/ACCUM, otherwise 0. The first stream bit
//   appears the cycle after entering WARMUP.
// - WARMUP: lasts exactly WARMUP cycles, with y_in ignored, then go to ACCUM.
// - ACCUM: lasts exactly STREAM_LEN cycles.
//   - ones counter (WIDTH+1 bits) += y_in each cycle.
//   - On the last cycle, result <= min(count_incl_last_bit, 2**WIDTH-1), then go to DONE.
// - DONE: out_valid=1. result is held stable until the out handshake, then go to IDLE with
//   out_valid=0. result keeps its value in IDLE until the next DONE.
// - Latency: in handshake to out_valid = WARMUP+STREAM_LEN+1 cycles.
// - abort in WARMUP/ACCUM: return to IDLE next cycle, x_out=0, no out_valid, result unchanged.
//   abort in IDLE/DONE is ignored; a pending result is not dropped.
// - in_valid held high during DONE is not accepted until after the out handshake (no overlap).
// - out_ready held high on entering DONE gives one-cycle out_valid; return to IDLE the next cycle.
// - Async reset mid-evaluation discards all state; no partial result is emitted.
// - y_in is sampled only in ACCUM; X on y_in outside ACCUM must not propagate.
// TESTING
// 1 Reset: n_rst low mid-ACCUM -> same-cycle in_ready=1, busy=0, out_valid=0, x_out=0, result=0.
// 2 in_value=0, y_in looped to x_out -> x_out all 0; result=0 after 16+256+1 cycles.
// 3 in_value=8'hFF, y_in tied 1 -> count=256 saturates, result=8'hFF, out_valid held while
//   out_ready=0 for 10 cycles.
// 4 in_value=8'h80, loopback, SEED=8'h5A -> result equals the golden model's exact LFSR count
//   (127 or 128); rerun gives an identical result (SEED reload).
// 5 abort at ACCUM cycle 100 -> IDLE next cycle, no out_valid, result keeps previous value,
//   new operand accepted.
// 6 Back-to-back: in_valid and out_ready held high, three operands -> three results in order,
//   each exactly 273 cycles after its accept, in_ready low throughout.

Source files
------------

// File: rtl/sigmoid_eval_ctrl.sv
// Sequences one stochastic sigmoid evaluation: operand -> LFSR-compared bitstream on x_out,
// warm-up settle, ones-count of y_in over a fixed window, result returned on a handshake.
module sigmoid_eval_ctrl #(
    parameter int unsigned      WIDTH      = 8,
    parameter int unsigned      STREAM_LEN = 256,
    parameter int unsigned      WARMUP     = 16,
    parameter logic [WIDTH-1:0] SEED       = WIDTH'(8'h5A),
    parameter logic [WIDTH-1:0] LFSR_TAPS  = WIDTH'(8'hB8)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    input  logic             abort,
    output logic             x_out,
    input  logic             y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and the offering side holds its data until the transfer.
    typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_ACCUM, S_DONE} state_t;

    localparam int unsigned     CYC_MAX    = (WARMUP > STREAM_LEN) ? WARMUP : STREAM_LEN;
    localparam int unsigned     CYC_W      = $clog2(CYC_MAX);
    localparam logic [CYC_W-1:0] WARM_LAST  = CYC_W'(WARMUP - 1);
    localparam logic [CYC_W-1:0] ACCUM_LAST = CYC_W'(STREAM_LEN - 1);
    localparam logic [WIDTH:0]   SAT        = {1'b0, {WIDTH{1'b1}}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [WIDTH:0]   ones_q, ones_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             x_out_q, x_out_d;
    logic             lfsr_fb;
    logic [WIDTH:0]   ones_sum;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (in_valid) state_d = S_WARMUP;
            S_WARMUP: begin
                if (abort)                   state_d = S_IDLE;
                else if (cyc_q == WARM_LAST) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (abort)                    state_d = S_IDLE;
                else if (cyc_q == ACCUM_LAST) state_d = S_DONE;
            end
            S_DONE:   if (out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_WARMUP) || (state_q == S_ACCUM);
        x_out     = x_out_q;
        result    = result_q;
        dbg_state = state_q;
    end

    // y_in only reaches ones_d inside ACCUM, so an unknown y_in elsewhere stays out of the count.
    always_comb begin
        value_d  = value_q;
        lfsr_d   = lfsr_q;
        cyc_d    = cyc_q;
        ones_d   = ones_q;
        result_d = result_q;
        x_out_d  = 1'b0;
        lfsr_fb  = ^(lfsr_q & LFSR_TAPS);
        ones_sum = ones_q + {{WIDTH{1'b0}}, y_in};
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    value_d = in_value;
                    lfsr_d  = SEED;
                    cyc_d   = '0;
                    ones_d  = '0;
                end
            end
            S_WARMUP: begin
                lfsr_d  = {lfsr_q[WIDTH-2:0], lfsr_fb};
                x_out_d = !abort && (value_q > lfsr_q);
                cyc_d   = (cyc_q == WARM_LAST) ? '0 : cyc_q + 1'b1;
            end
            S_ACCUM: begin
                lfsr_d  = {lfsr_q[WIDTH-2:0], lfsr_fb};
                x_out_d = !abort && (value_q > lfsr_q);
                cyc_d   = cyc_q + 1'b1;
                ones_d  = ones_sum;
                if ((cyc_q == ACCUM_LAST) && !abort)
                    result_d = (ones_sum > SAT) ? '1 : ones_sum[WIDTH-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            value_q  <= '0;
            lfsr_q   <= SEED;
            cyc_q    <= '0;
            ones_q   <= '0;
            result_q <= '0;
            x_out_q  <= 1'b0;
        end else begin
            value_q  <= value_d;
            lfsr_q   <= lfsr_d;
            cyc_q    <= cyc_d;
            ones_q   <= ones_d;
            result_q <= result_d;
            x_out_q  <= x_out_d;
        end
    end

endmodule

// File: tb/tb_sigmoid_eval_ctrl.sv
// Randomised bench for sigmoid_eval_ctrl: reference model of the seeded LFSR stream, the
// accumulate window and the result timing, checked scenario by scenario.
module tb_sigmoid_eval_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_value;
    logic       abort;
    logic       x_out;
    logic       y_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       busy;
    logic [1:0] dbg_state;

    logic       loopback;
    logic       y_drv;
    bit         hold_valid;
    int         n_tests;
    int         n_fail;
    int         rdy_hi;
    logic [7:0] seq [0:254];
    logic       xs [0:400];

    localparam int LAT = 273;

    assign y_in = loopback ? x_out : y_drv;

    always #5 clk = ~clk;

    sigmoid_eval_ctrl dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .abort     (abort),
        .x_out     (x_out),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // LFSR state sequence from seed 0x5A, polynomial x^8+x^6+x^5+x^4+1, shifting left.
    task automatic build_seq();
        int l;
        int fb;
        l = 'h5A;
        for (int i = 0; i < 255; i++) begin
            seq[i] = l[7:0];
            fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
            l  = ((l << 1) | fb) & 255;
        end
    endtask

    // Stream bit j compares the operand with LFSR state j; loopback sees it one cycle late,
    // so the 256-cycle window after 16 warm-up cycles covers stream bits 15..270.
    function automatic int loop_count(input int v);
        int c = 0;
        for (int j = 15; j <= 270; j++) if (v > int'(seq[j % 255])) c++;
        return (c > 255) ? 255 : c;
    endfunction

    function automatic int x_errs(input int v);
        int   e = 0;
        logic ex;
        for (int t = 1; t <= 272; t++) begin
            ex = (t == 1) ? 1'b0 : (v > int'(seq[(t - 2) % 255]));
            if (xs[t] !== ex) e++;
        end
        return e;
    endfunction

    // Offers one operand from IDLE and follows it until out_valid (or a cycle budget expires).
    // y_mode: 0 loopback, 1 random, 2 tied high, 3 tied low.
    task automatic run_eval(input logic [7:0] v, input int y_mode,
                            output int lat, output logic [7:0] got, output int exp_ones);
        lat = -1; got = '0; exp_ones = 0; rdy_hi = 0;
        loopback = (y_mode == 0);
        in_value = v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = hold_valid;
        for (int t = 1; t <= 400; t++) begin
            if (out_valid) begin
                lat = t;
                got = result;
                break;
            end
            xs[t] = x_out;
            if (in_ready) rdy_hi++;
            case (y_mode)
                1:       y_drv = 1'($urandom_range(0, 1));
                2:       y_drv = 1'b1;
                default: y_drv = 1'b0;
            endcase
            if (y_mode != 0 && t >= 17 && t <= 272) exp_ones += int'(y_drv);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b1; in_valid = 1'b0; in_value = '0; abort = 1'b0; out_ready = 1'b0;
        loopback = 1'b0; y_drv = 1'b0; hold_valid = 1'b0;
        #2 n_rst = 1'b0;
        #2;
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || x_out !== 1'b0 || result !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b busy=%b out_valid=%b x_out=%b result=%h, required 1 0 0 0 00",
                     in_ready, busy, out_valid, x_out, result);
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        int lat, ex; logic [7:0] got;
        run_eval(8'h00, 0, lat, got, ex);
        n_tests++;
        if (lat !== LAT) begin n_fail++; $display("FAIL zero_latency: got %0d required %0d", lat, LAT); end
        n_tests++;
        if (got !== 8'h00) begin n_fail++; $display("FAIL zero_result: got %h required 00", got); end
        n_tests++;
        if (x_errs(0) != 0) begin n_fail++; $display("FAIL zero_xstream: %0d bits wrong, required 0", x_errs(0)); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL zero_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_saturate();
        int lat, ex, held; logic [7:0] got;
        run_eval(8'hFF, 2, lat, got, ex);
        n_tests++;
        if (lat !== LAT) begin n_fail++; $display("FAIL sat_latency: got %0d required %0d", lat, LAT); end
        n_tests++;
        if (got !== 8'((ex > 255) ? 255 : ex)) begin n_fail++; $display("FAIL sat_result: got %h required %h", got, 8'hFF); end
        n_tests++;
        if (x_errs(255) != 0) begin n_fail++; $display("FAIL sat_xstream: %0d bits wrong, required 0", x_errs(255)); end
        held = 0;
        abort = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1 && result === 8'hFF) held++;
        end
        abort = 1'b0;
        n_tests++;
        if (held != 10) begin n_fail++; $display("FAIL sat_hold: held %0d cycles required 10", held); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_release: out_valid=%b required 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        int ov;
        loopback = 1'b0; y_drv = 1'b1;
        in_value = 8'hFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (150) begin @(posedge clk); #1; end
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: busy=%b required 1", busy); end
        n_rst = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || x_out !== 1'b0 || result !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_state: in_ready=%b busy=%b out_valid=%b x_out=%b result=%h, required 1 0 0 0 00",
                     in_ready, busy, out_valid, x_out, result);
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
        ov = 0;
        repeat (300) begin @(posedge clk); #1; if (out_valid !== 1'b0) ov++; end
        n_tests++;
        if (ov != 0) begin n_fail++; $display("FAIL midreset_no_result: out_valid seen %0d cycles required 0", ov); end
    endtask

    task automatic test_golden();
        int lat, ex; logic [7:0] got;
        for (int r = 0; r < 2; r++) begin
            run_eval(8'h80, 0, lat, got, ex);
            n_tests++;
            if (lat !== LAT) begin n_fail++; $display("FAIL golden_latency run %0d: got %0d required %0d", r, lat, LAT); end
            n_tests++;
            if (got !== 8'(loop_count(128))) begin
                n_fail++; $display("FAIL golden_result run %0d: got %0d required %0d", r, got, loop_count(128));
            end
            n_tests++;
            if (x_errs(128) != 0) begin n_fail++; $display("FAIL golden_xstream run %0d: %0d bits wrong", r, x_errs(128)); end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_abort();
        int lat, ex, ov, at; logic [7:0] got, prev, v;
        prev = 8'(loop_count(128));
        for (int k = 0; k < 2; k++) begin
            at = (k == 0) ? 5 : 116;
            loopback = 1'b0;
            in_value = 8'($urandom_range(0, 255)); in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int t = 1; t < at; t++) begin
                y_drv = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            n_tests++;
            if (in_ready !== 1'b1 || busy !== 1'b0 || x_out !== 1'b0 || out_valid !== 1'b0 || result !== prev) begin
                n_fail++;
                $display("FAIL abort_at_%0d: in_ready=%b busy=%b x_out=%b out_valid=%b result=%h, required 1 0 0 0 %h",
                         at, in_ready, busy, x_out, out_valid, result, prev);
            end
            ov = 0;
            repeat (20) begin @(posedge clk); #1; if (out_valid !== 1'b0) ov++; end
            n_tests++;
            if (ov != 0) begin n_fail++; $display("FAIL abort_no_result_%0d: out_valid %0d cycles required 0", at, ov); end
        end
        v = 8'($urandom_range(0, 255));
        run_eval(v, 1, lat, got, ex);
        n_tests++;
        if (lat !== LAT || got !== 8'((ex > 255) ? 255 : ex)) begin
            n_fail++; $display("FAIL abort_next_eval: lat %0d result %0d, required %0d %0d", lat, got, LAT, ex);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int lat, ex, dly, held; logic [7:0] got, v;
        for (int n = 0; n < 4; n++) begin
            v = 8'($urandom_range(0, 255));
            run_eval(v, 1, lat, got, ex);
            n_tests++;
            if (lat !== LAT || got !== 8'((ex > 255) ? 255 : ex)) begin
                n_fail++; $display("FAIL random_%0d v=%h: lat %0d result %0d, required %0d %0d", n, v, lat, got, LAT, ex);
            end
            n_tests++;
            if (x_errs(int'(v)) != 0) begin n_fail++; $display("FAIL random_xstream_%0d: %0d bits wrong", n, x_errs(int'(v))); end
            dly = $urandom_range(0, 3);
            held = 0;
            for (int i = 0; i < dly; i++) begin @(posedge clk); #1; if (out_valid === 1'b1) held++; end
            n_tests++;
            if (held != dly) begin n_fail++; $display("FAIL random_hold_%0d: held %0d required %0d", n, held, dly); end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int lat, ex; logic [7:0] got;
        logic [7:0] ops [0:2];
        for (int k = 0; k < 3; k++) ops[k] = 8'($urandom_range(0, 255));
        hold_valid = 1'b1;
        out_ready  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_eval(ops[k], 1, lat, got, ex);
            n_tests++;
            if (lat !== LAT || got !== 8'((ex > 255) ? 255 : ex)) begin
                n_fail++; $display("FAIL b2b_%0d: lat %0d result %0d, required %0d %0d", k, lat, got, LAT, ex);
            end
            n_tests++;
            if (rdy_hi != 0) begin n_fail++; $display("FAIL b2b_ready_%0d: in_ready high %0d cycles required 0", k, rdy_hi); end
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b_release_%0d: out_valid=%b in_ready=%b required 0 1", k, out_valid, in_ready);
            end
        end
        hold_valid = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        build_seq();
        test_reset();
        test_zero();
        test_saturate();
        test_reset_mid();
        test_golden();
        test_abort();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
